pingpong_map_buffer: RTL and testbench
======================================

Name: pingpong_map_buffer

Overview:
Parametrised dual-bank (ping-pong) feature-map buffer for the ECG accelerator. It stores one layer's output map from the selected producer (ECG input, R&P, or FC) in the write bank, while the Input_Regfile path reads the previous layer's map from the other bank. Bank role is swapped by an explicit handshake rather than a layer-index bit. The buffer tracks per-bank fill counts and reports sticky address and protocol errors.

Parameters:
LANES, 8, number of parallel byte lanes per word
DW, 8, bits per lane
AW, 13, address width of wr_addr/rd_addr
DEPTH, 2048, words per bank; valid addresses are 0..DEPTH-1
FW, 14, fill-counter width; must satisfy 2^FW > DEPTH

Ports:
clk_cal  in  1  clock
rst_cal_n  in  1  asynchronous active-low reset
src_sel  in  2  write source: 0=R&P, 1=FC, 2=ECG, 3=none
rp_vld  in  1  R&P write strobe
rp_data  in  LANES*DW  R&P word; lane i is bits [i*DW +: DW]
fc_vld  in  1  FC write strobe
fc_data  in  LANES*DW  FC word
ecg_vld  in  1  ECG write strobe
ecg_data  in  LANES*DW  ECG word
lane_mask  in  LANES  per-lane write enable
wr_addr  in  AW  write address
rd_en  in  1  read request
rd_addr  in  AW  read address
dout  out  LANES*DW  read data
dout_vld  out  1  read data valid
swap_req  in  1  bank-swap request pulse
swap_ack  out  1  one-cycle swap-complete pulse
busy  out  1  swap in progress
wr_bank  out  1  bank currently written (0=A, 1=B); read bank is ~wr_bank
rd_fill  out  FW  accepted write beats in the current read bank
err_oor  out  1  sticky: out-of-range address
err_busy  out  1  sticky: access attempted while busy
err_clr  in  1  clears sticky errors

Behaviour:
- Reset values: dout=0, dout_vld=0, swap_ack=0, busy=0, wr_bank=0, rd_fill=0, internal wr_fill=0, err_oor=0, err_busy=0, FSM=IDLE. RAM contents are undefined after reset.
- Source mux is combinational:
  - src_sel=0: vld=rp_vld, data=rp_data; 1: fc pair; 2: ecg pair; 3: vld=0.
- Write acceptance: a write is accepted when vld=1, busy=0, and wr_addr<DEPTH.
  - Lane i of bank wr_bank[wr_addr] is written at the clock edge only if lane_mask[i]=1.
  - Each accepted beat increments wr_fill (saturating at DEPTH), including beats with lane_mask=0.
- Read acceptance: a read is accepted when rd_en=1, busy=0, and rd_addr<DEPTH.
  - Data comes from bank ~wr_bank.
  - Latency is 1: dout and dout_vld=1 are registered on the next edge.
  - When no read is accepted, dout_vld=0 and dout holds its last value.
- Out of range: vld or rd_en with an address >=DEPTH while busy=0.
  - The access is dropped and err_oor is set.
  - An out-of-range read produces no dout_vld.
- Busy: vld or rd_en while busy=1 is dropped and err_busy is set.
- Sticky errors: err_clr=1 clears both errors. If a set event occurs in the same cycle, set wins.
- Swap FSM, states IDLE -> DRAIN -> SWAP -> ACK -> IDLE:
  - IDLE: swap_req=1 moves to DRAIN. A write or read accepted in that same cycle completes against the old bank roles.
  - DRAIN: busy=1; lets the last read output retire. Lasts 1 cycle.
  - SWAP: busy=1; wr_bank<=~wr_bank, rd_fill<=wr_fill, wr_fill<=0.
  - ACK: busy=1, swap_ack=1 for exactly one cycle; then IDLE with busy=0.
  - Total: a swap_req at cycle N gives busy high N+1..N+3, wr_bank toggled visible from N+3, swap_ack at N+3.
- swap_req while busy=1 is ignored and does not set err_busy.
- Reset asserted mid-swap returns immediately to IDLE with all reset values.

Test Plan:
- Reset, src_sel=2, write ecg words 0x0807060504030201+k to addr 0..3, lane_mask=0xFF; swap -> swap_ack once 3 cycles after the req cycle, wr_bank=1, rd_fill=4; read addr 2 -> next cycle dout=0x0807060504030203, dout_vld=1.
- src_sel=1, write FC 0xFFFF...FF to addr 5 with lane_mask=0x0F, then a full-mask zero word earlier at same addr; swap; read addr 5 -> dout=0x00000000FFFFFFFF.
- Write addr 2048 and read addr 4095 -> no RAM change, no dout_vld, err_oor=1; pulse err_clr -> err_oor=0.
- swap_req with rp_vld=1 same cycle at addr 7 -> write lands in old write bank; rp_vld during busy -> dropped, err_busy=1, rd_fill excludes it; second swap_req during busy -> ignored, only one swap_ack.
- Write 2100 beats cycling addr 0..2047 then repeat 52 -> after swap rd_fill=2048 (saturated); back-to-back reads addr 0..9 -> dout_vld high 10 consecutive cycles, one cycle delayed.
- Deassert rst_cal_n during DRAIN -> busy=0, wr_bank=0, rd_fill=0, swap_ack never pulses.

Source files
------------

// File: rtl/pingpong_map_buffer_if.sv
// Bus interface for the ping-pong feature-map buffer: producer writes, consumer
// reads, bank-swap handshake and sticky error status.
interface pingpong_map_buffer_if #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int AW    = 13,
  parameter int FW    = 14
);
  logic [1:0]          src_sel;
  logic                rp_vld;
  logic [LANES*DW-1:0] rp_data;
  logic                fc_vld;
  logic [LANES*DW-1:0] fc_data;
  logic                ecg_vld;
  logic [LANES*DW-1:0] ecg_data;
  logic [LANES-1:0]    lane_mask;
  logic [AW-1:0]       wr_addr;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [LANES*DW-1:0] dout;
  logic                dout_vld;
  logic                swap_req;
  logic                swap_ack;
  logic                busy;
  logic                wr_bank;
  logic [FW-1:0]       rd_fill;
  logic                err_oor;
  logic                err_busy;
  logic                err_clr;

  modport master (
    output src_sel, rp_vld, rp_data, fc_vld, fc_data, ecg_vld, ecg_data,
    output lane_mask, wr_addr, rd_en, rd_addr, swap_req, err_clr,
    input  dout, dout_vld, swap_ack, busy, wr_bank, rd_fill, err_oor, err_busy
  );

  modport slave (
    input  src_sel, rp_vld, rp_data, fc_vld, fc_data, ecg_vld, ecg_data,
    input  lane_mask, wr_addr, rd_en, rd_addr, swap_req, err_clr,
    output dout, dout_vld, swap_ack, busy, wr_bank, rd_fill, err_oor, err_busy
  );
endinterface

// File: rtl/pingpong_map_buffer.sv
// Dual-bank feature-map buffer: one bank is filled by the selected producer while
// the other is read; roles swap through a DRAIN/SWAP/ACK handshake.
module pingpong_map_buffer #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int AW    = 13,
  parameter int DEPTH = 2048,
  parameter int FW    = 14
) (
  input  logic                  clk_cal,
  input  logic                  rst_cal_n,
  pingpong_map_buffer_if.slave  bus
);

  localparam int WW = LANES * DW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'(DEPTH);
  localparam logic [FW-1:0] FILL_MAX   = FW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SWAP,
    S_ACK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WW-1:0]   r_mem [2][DEPTH];
  logic [WW-1:0]   r_dout;
  logic            r_dout_vld;
  logic            r_wr_bank;
  logic [FW-1:0]   r_wr_fill;
  logic [FW-1:0]   r_rd_fill;
  logic            r_err_oor;
  logic            r_err_busy;

  logic            w_vld;
  logic [WW-1:0]   w_data;
  logic            w_busy;
  logic            w_wr_in_range;
  logic            w_rd_in_range;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_set_oor;
  logic            w_set_busy;
  logic [IW-1:0]   w_wr_idx;
  logic [IW-1:0]   w_rd_idx;

  // Producer select
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_vld  = 1'b0;
    w_data = '0;
    unique case (bus.src_sel)
      2'd0: begin
        w_vld  = bus.rp_vld;
        w_data = bus.rp_data;
      end
      2'd1: begin
        w_vld  = bus.fc_vld;
        w_data = bus.fc_data;
      end
      2'd2: begin
        w_vld  = bus.ecg_vld;
        w_data = bus.ecg_data;
      end
      default: begin
        w_vld  = 1'b0;
        w_data = '0;
      end
    endcase
  end

  assign w_busy        = (r_state != S_IDLE);
  assign w_wr_in_range = ({1'b0, bus.wr_addr} < ADDR_LIMIT);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < ADDR_LIMIT);
  assign w_wr_acc      = w_vld & ~w_busy & w_wr_in_range;
  assign w_rd_acc      = bus.rd_en & ~w_busy & w_rd_in_range;
  assign w_set_oor     = ~w_busy & ((w_vld & ~w_wr_in_range) | (bus.rd_en & ~w_rd_in_range));
  assign w_set_busy    = w_busy & (w_vld | bus.rd_en);
  assign w_wr_idx      = bus.wr_addr[IW-1:0];
  assign w_rd_idx      = bus.rd_addr[IW-1:0];

  // Swap handshake: state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Swap handshake: next state; swap_req outside IDLE is ignored
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.swap_req) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_SWAP;
      S_SWAP:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane-masked storage, write side always targets the current write bank
  // NOTE: the RAM arrays are deliberately not reset; clearing them would turn
  // the block RAM into thousands of flops, and contents are undefined after reset.
  always_ff @(posedge clk_cal) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_wr_acc && bus.lane_mask[i]) begin
        r_mem[r_wr_bank][w_wr_idx][i*DW +: DW] <= w_data[i*DW +: DW];
      end
    end
  end

  // Read port: one-cycle latency from the bank opposite the write bank
  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[~r_wr_bank][w_rd_idx];
      end
    end
  end

  // Bank roles and fill counts; the write fill saturates at one full bank
  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      r_wr_bank <= 1'b0;
      r_wr_fill <= '0;
      r_rd_fill <= '0;
    end else if (r_state == S_SWAP) begin
      r_wr_bank <= ~r_wr_bank;
      r_rd_fill <= r_wr_fill;
      r_wr_fill <= '0;
    end else if (w_wr_acc && (r_wr_fill < FILL_MAX)) begin
      r_wr_fill <= r_wr_fill + FW'(1);
    end
  end

  // Sticky errors: a set event in the clearing cycle wins
  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      r_err_oor  <= 1'b0;
      r_err_busy <= 1'b0;
    end else begin
      r_err_oor  <= w_set_oor  | (r_err_oor  & ~bus.err_clr);
      r_err_busy <= w_set_busy | (r_err_busy & ~bus.err_clr);
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.swap_ack = (r_state == S_ACK);
  assign bus.busy     = w_busy;
  assign bus.wr_bank  = r_wr_bank;
  assign bus.rd_fill  = r_rd_fill;
  assign bus.err_oor  = r_err_oor;
  assign bus.err_busy = r_err_busy;

endmodule

// File: tb/tb_pingpong_map_buffer.sv
// Self-checking bench for pingpong_map_buffer: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the buffer.
module tb_pingpong_map_buffer;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int AW    = 13;
  localparam int DEPTH = 2048;
  localparam int FW    = 14;

  logic clk_cal = 1'b0;
  logic rst_cal_n;

  always #5 clk_cal = ~clk_cal;

  pingpong_map_buffer_if #(.LANES(LANES), .DW(DW), .AW(AW), .FW(FW)) bus ();

  pingpong_map_buffer #(
    .LANES(LANES), .DW(DW), .AW(AW), .DEPTH(DEPTH), .FW(FW)
  ) dut (
    .clk_cal  (clk_cal),
    .rst_cal_n(rst_cal_n),
    .bus      (bus.slave)
  );

  // Reference model: two plain word arrays, per-lane "written" flags, and a
  // countdown of remaining busy cycles for a swap in flight.
  logic [63:0] m_mem [2][DEPTH];
  logic [7:0]  m_val [2][DEPTH];
  int          m_wr_bank;
  int          m_wr_fill;
  int          m_rd_fill;
  int          m_swap_left;
  bit          m_err_oor;
  bit          m_err_busy;
  bit          m_vld;
  logic [63:0] m_dout;
  logic [63:0] m_mask;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    m_wr_bank   = 0;
    m_wr_fill   = 0;
    m_rd_fill   = 0;
    m_swap_left = 0;
    m_err_oor   = 0;
    m_err_busy  = 0;
    m_vld       = 0;
    m_dout      = '0;
    m_mask      = '1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_val[b][a] = '0;
  endtask

  task automatic drive_idle();
    bus.src_sel   = 2'd3;
    bus.rp_vld    = 1'b0;
    bus.rp_data   = '0;
    bus.fc_vld    = 1'b0;
    bus.fc_data   = '0;
    bus.ecg_vld   = 1'b0;
    bus.ecg_data  = '0;
    bus.lane_mask = '0;
    bus.wr_addr   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.swap_req  = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic check_outputs();
    check("dout_vld", 64'(bus.dout_vld), 64'(m_vld));
    check("dout",     bus.dout & m_mask, m_dout & m_mask);
    check("busy",     64'(bus.busy),     64'(m_swap_left != 0));
    check("swap_ack", 64'(bus.swap_ack), 64'(m_swap_left == 1));
    check("wr_bank",  64'(bus.wr_bank),  64'(m_wr_bank));
    check("rd_fill",  64'(bus.rd_fill),  64'(m_rd_fill));
    check("err_oor",  64'(bus.err_oor),  64'(m_err_oor));
    check("err_busy", 64'(bus.err_busy), 64'(m_err_busy));
  endtask

  // Advance one clock: model the edge from the currently driven inputs, then
  // compare every output 1 time unit after the edge.
  task automatic cycle();
    logic        sel_vld;
    logic [63:0] sel_data;
    bit          busy_now, set_oor, set_busy;
    int          wa, ra, rb;
    sel_vld  = 1'b0;
    sel_data = '0;
    case (bus.src_sel)
      2'd0: begin sel_vld = bus.rp_vld;  sel_data = bus.rp_data;  end
      2'd1: begin sel_vld = bus.fc_vld;  sel_data = bus.fc_data;  end
      2'd2: begin sel_vld = bus.ecg_vld; sel_data = bus.ecg_data; end
      default: sel_vld = 1'b0;
    endcase
    busy_now = (m_swap_left != 0);
    set_oor  = 0;
    set_busy = 0;
    m_vld    = 0;
    wa = int'(bus.wr_addr);
    ra = int'(bus.rd_addr);
    rb = 1 - m_wr_bank;
    if (!busy_now) begin
      if (sel_vld) begin
        if (wa < DEPTH) begin
          for (int i = 0; i < 8; i++) begin
            if (bus.lane_mask[i]) begin
              m_mem[m_wr_bank][wa][i*8 +: 8] = sel_data[i*8 +: 8];
              m_val[m_wr_bank][wa][i] = 1'b1;
            end
          end
          if (m_wr_fill < DEPTH) m_wr_fill++;
        end else begin
          set_oor = 1;
        end
      end
      if (bus.rd_en) begin
        if (ra < DEPTH) begin
          m_dout = m_mem[rb][ra];
          m_mask = lane_bits(m_val[rb][ra]);
          m_vld  = 1;
        end else begin
          set_oor = 1;
        end
      end
    end else if (sel_vld || bus.rd_en) begin
      set_busy = 1;
    end
    m_err_oor  = set_oor  | (m_err_oor  & !bus.err_clr);
    m_err_busy = set_busy | (m_err_busy & !bus.err_clr);
    if (m_swap_left == 0) begin
      if (bus.swap_req && rst_cal_n) m_swap_left = 3;
    end else begin
      if (m_swap_left == 2) begin
        m_wr_bank = 1 - m_wr_bank;
        m_rd_fill = m_wr_fill;
        m_wr_fill = 0;
      end
      m_swap_left--;
    end
    @(posedge clk_cal);
    #1;
    if (bus.swap_ack === 1'b1) n_acks++;
    check_outputs();
  endtask

  task automatic wr(input logic [1:0] sel, input int addr, input logic [63:0] data,
                    input logic [7:0] mask);
    drive_idle();
    bus.src_sel   = sel;
    bus.lane_mask = mask;
    bus.wr_addr   = AW'(addr);
    case (sel)
      2'd0: begin bus.rp_vld  = 1'b1; bus.rp_data  = data; end
      2'd1: begin bus.fc_vld  = 1'b1; bus.fc_data  = data; end
      default: begin bus.ecg_vld = 1'b1; bus.ecg_data = data; end
    endcase
    cycle();
    drive_idle();
  endtask

  task automatic rd(input int addr);
    drive_idle();
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    cycle();
    drive_idle();
  endtask

  task automatic do_swap();
    int acks0;
    acks0 = n_acks;
    drive_idle();
    bus.swap_req = 1'b1;
    cycle();
    drive_idle();
    repeat (3) cycle();
    check("swap_ack_count", 64'(n_acks - acks0), 64'd1);
  endtask

  initial begin
    int acks0;
    drive_idle();
    rst_cal_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk_cal);
    #1;
    rst_cal_n = 1'b1;
    check_outputs();

    // ECG words into bank A, swap, read back
    for (int k = 0; k < 4; k++) wr(2'd2, k, 64'h0807060504030201 + 64'(k), 8'hFF);
    do_swap();
    check("t1_wr_bank", 64'(bus.wr_bank), 64'd1);
    check("t1_rd_fill", 64'(bus.rd_fill), 64'd4);
    rd(2);
    check("t1_dout_vld", 64'(bus.dout_vld), 64'd1);
    check("t1_dout", bus.dout, 64'h0807060504030203);

    // FC partial-lane overwrite
    wr(2'd1, 5, 64'h0, 8'hFF);
    wr(2'd1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_swap();
    rd(5);
    check("t2_dout", bus.dout, 64'h0000_0000_FFFF_FFFF);

    // Out-of-range access and sticky clear
    drive_idle();
    bus.src_sel  = 2'd2;
    bus.ecg_vld  = 1'b1;
    bus.ecg_data = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.lane_mask = 8'hFF;
    bus.wr_addr  = AW'(2048);
    bus.rd_en    = 1'b1;
    bus.rd_addr  = AW'(4095);
    cycle();
    drive_idle();
    check("t3_no_vld", 64'(bus.dout_vld), 64'd0);
    check("t3_err_oor", 64'(bus.err_oor), 64'd1);
    bus.err_clr = 1'b1;
    cycle();
    drive_idle();
    check("t3_err_clr", 64'(bus.err_oor), 64'd0);

    // Write in the swap_req cycle, writes and a second request while busy
    acks0 = n_acks;
    drive_idle();
    bus.src_sel   = 2'd0;
    bus.rp_vld    = 1'b1;
    bus.rp_data   = 64'hA5A5_0000_1234_5678;
    bus.lane_mask = 8'hFF;
    bus.wr_addr   = AW'(7);
    bus.swap_req  = 1'b1;
    cycle();
    bus.wr_addr   = AW'(8);
    bus.rp_data   = 64'h1111_2222_3333_4444;
    cycle();
    drive_idle();
    repeat (2) cycle();
    check("t4_err_busy", 64'(bus.err_busy), 64'd1);
    check("t4_rd_fill", 64'(bus.rd_fill), 64'd1);
    check("t4_one_ack", 64'(n_acks - acks0), 64'd1);
    rd(7);
    check("t4_dout", bus.dout, 64'hA5A5_0000_1234_5678);
    bus.err_clr = 1'b1;
    cycle();
    drive_idle();

    // Fill saturation and back-to-back reads
    for (int i = 0; i < 2100; i++)
      wr(2'd2, i % DEPTH, {$urandom(), $urandom()}, 8'hFF);
    do_swap();
    check("t5_rd_fill_sat", 64'(bus.rd_fill), 64'd2048);
    check("t5_vld_before", 64'(bus.dout_vld), 64'd0);
    for (int i = 0; i < 10; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(i);
      cycle();
      check("t5_vld_stream", 64'(bus.dout_vld), 64'd1);
    end
    drive_idle();
    cycle();
    check("t5_vld_after", 64'(bus.dout_vld), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      drive_idle();
      bus.src_sel   = 2'($urandom_range(0, 3));
      bus.rp_vld    = 1'($urandom_range(0, 1));
      bus.fc_vld    = 1'($urandom_range(0, 1));
      bus.ecg_vld   = 1'($urandom_range(0, 1));
      bus.rp_data   = {$urandom(), $urandom()};
      bus.fc_data   = {$urandom(), $urandom()};
      bus.ecg_data  = {$urandom(), $urandom()};
      bus.lane_mask = 8'($urandom());
      bus.wr_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(2048, 8191))
                                                  : AW'($urandom_range(0, 63));
      bus.rd_en     = 1'($urandom_range(0, 1));
      bus.rd_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(2048, 8191))
                                                  : AW'($urandom_range(0, 63));
      bus.swap_req  = ($urandom_range(0, 29) == 0);
      bus.err_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drive_idle();
    repeat (4) cycle();

    // Reset asserted during DRAIN
    acks0 = n_acks;
    bus.swap_req = 1'b1;
    cycle();
    drive_idle();
    check("t6_in_drain", 64'(bus.busy), 64'd1);
    rst_cal_n = 1'b0;
    model_reset();
    #1;
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_wr_bank", 64'(bus.wr_bank), 64'd0);
    check("t6_rd_fill", 64'(bus.rd_fill), 64'd0);
    repeat (3) cycle();
    rst_cal_n = 1'b1;
    repeat (4) cycle();
    check("t6_no_ack", 64'(n_acks - acks0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
